// File: rtl/fp_mult_pkg.sv
// Shared definitions for the FP arithmetic cluster (multiplier, adder).
// Contents:
//   fp_class_e       operand classification
//   FLAG_*           bit positions inside the 4-bit exception flag vector
//   bias_of()        exponent bias for a given exponent width
//   reg_size_of()    total encoded width for given exponent/fraction widths
//   qnan()           canonical quiet NaN, right-aligned in 64 bits
package fp_mult_pkg;

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_SUB,
      CLS_NORM,
      CLS_INF,
      CLS_NAN
   } fp_class_e;

   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   function automatic int bias_of(input int exp_size);
      return (1 << (exp_size - 1)) - 1;
   endfunction

   function automatic int reg_size_of(input int exp_size, input int fra_size);
      return 1 + exp_size + fra_size;
   endfunction

   // Positive sign, all-ones exponent, fraction MSB set and the rest clear.
   function automatic logic [63:0] qnan(input int exp_size, input int fra_size);
      logic [63:0] v;
      v = ((64'd1 << exp_size) - 64'd1) << fra_size;
      v = v | (64'd1 << (fra_size - 1));
      return v;
   endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle of the FP multiplier.
//   in_valid_44 / in_ready_44    operand handshake
//   mult_a_44 / mult_b_44        operands
//   out_valid_44 / out_ready_44  result handshake
//   mult_out_44 / flags_44       product and {invalid, overflow, underflow, inexact}
// master: the side supplying operands and consuming results; slave: the multiplier.
interface fp_mult_pipe_if
   import fp_mult_pkg::*;
#(
   parameter int EXP_SIZE = 5,
   parameter int FRA_SIZE = 10
);
   localparam int REG_SIZE = reg_size_of(EXP_SIZE, FRA_SIZE);

   logic                in_valid_44;
   logic                in_ready_44;
   logic [REG_SIZE-1:0] mult_a_44;
   logic [REG_SIZE-1:0] mult_b_44;
   logic                out_valid_44;
   logic                out_ready_44;
   logic [REG_SIZE-1:0] mult_out_44;
   logic [3:0]          flags_44;

   modport master (
      output in_valid_44, mult_a_44, mult_b_44, out_ready_44,
      input  in_ready_44, out_valid_44, mult_out_44, flags_44
   );

   modport slave (
      input  in_valid_44, mult_a_44, mult_b_44, out_ready_44,
      output in_ready_44, out_valid_44, mult_out_44, flags_44
   );
endinterface

// File: rtl/fp_norm_round.sv
// Combinational normalise + round-to-nearest-even for the mantissa product.
//   prod     {1,fa}*{1,fb}, leading one at bit 2F+1 or 2F
//   exp_in   biased exponent sum (signed, EXP_SIZE+2 bits)
//   frac     rounded stored fraction
//   exp_out  exponent after normalise and round carry
//   inexact  any discarded bit was set
module fp_norm_round #(
   parameter int EXP_SIZE = 5,
   parameter int FRA_SIZE = 10
) (
   input  logic [2*FRA_SIZE+1:0] prod,
   input  logic [EXP_SIZE+1:0]   exp_in,
   output logic [FRA_SIZE-1:0]   frac,
   output logic [EXP_SIZE+1:0]   exp_out,
   output logic                  inexact
);
   localparam int XW = EXP_SIZE + 2;

   logic                hi;
   logic [2*FRA_SIZE:0] lower;
   logic [FRA_SIZE-1:0] frac_trunc;
   logic                guard;
   logic                sticky;
   logic                round_up;
   logic                carry;

   // Drop the leading one; an unshifted product is padded so that fraction,
   // guard and sticky always sit at the same positions.
   assign hi         = prod[2*FRA_SIZE+1];
   assign lower      = hi ? prod[2*FRA_SIZE:0] : {prod[2*FRA_SIZE-1:0], 1'b0};
   assign frac_trunc = lower[2*FRA_SIZE:FRA_SIZE+1];
   assign guard      = lower[FRA_SIZE];
   assign sticky     = |lower[FRA_SIZE-1:0];
   assign round_up   = guard & (sticky | frac_trunc[0]);

   // A carry out of the fraction means 1.11..1 rounded to 10.0: fraction wraps
   // to zero and the exponent takes the extra one.
   assign {carry, frac} = {1'b0, frac_trunc} + (FRA_SIZE+1)'(round_up);
   assign exp_out       = exp_in + XW'(hi) + XW'(carry);
   assign inexact       = guard | sticky;
endmodule

// File: rtl/fp_mult_pipe.sv
// Pipelined IEEE-754 multiplier (FTZ, round-to-nearest-even).
//   clk_44, reset_44   clock and synchronous active-high reset
//   bus                operand/result handshake (fp_mult_pipe_if.slave)
// Operand capture register, then S1 unpack/multiply, S2 normalise/round,
// S3 pack/special (output register). One global enable: everything holds
// while the output is valid and not taken.
module fp_mult_pipe
   import fp_mult_pkg::*;
#(
   parameter int EXP_SIZE = 5,
   parameter int FRA_SIZE = 10
) (
   input  logic          clk_44,
   input  logic          reset_44,
   fp_mult_pipe_if.slave bus
);
   localparam int REG_SIZE = reg_size_of(EXP_SIZE, FRA_SIZE);
   localparam int BIAS     = bias_of(EXP_SIZE);
   localparam int PW       = 2*FRA_SIZE + 2;
   localparam int XW       = EXP_SIZE + 2;
   localparam logic [63:0] QNAN_W = qnan(EXP_SIZE, FRA_SIZE);

   logic advance;
   assign advance         = ~(bus.out_valid_44 & ~bus.out_ready_44);
   assign bus.in_ready_44 = advance;

   logic v0_reg, v1_reg, v2_reg, v3_reg;

   always_ff @(posedge clk_44) begin
      if (reset_44) begin
         v0_reg <= 1'b0;
         v1_reg <= 1'b0;
         v2_reg <= 1'b0;
         v3_reg <= 1'b0;
      end else if (advance) begin
         v0_reg <= bus.in_valid_44;
         v1_reg <= v0_reg;
         v2_reg <= v1_reg;
         v3_reg <= v2_reg;
      end
   end
   assign bus.out_valid_44 = v3_reg;

   // Operand capture: only on an actual accept.
   logic [REG_SIZE-1:0] a0_reg, b0_reg;
   always_ff @(posedge clk_44) begin
      if (advance && bus.in_valid_44) begin
         a0_reg <= bus.mult_a_44;
         b0_reg <= bus.mult_b_44;
      end
   end

   // S1: classify both operands; subnormals flush to zero.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_unpack
         logic [EXP_SIZE-1:0] ex;
         logic [FRA_SIZE-1:0] fr;
         fp_class_e           cls;
         fp_class_e           cls_ftz;
         logic                snan;

         assign ex = (gi == 0) ? a0_reg[REG_SIZE-2:FRA_SIZE] : b0_reg[REG_SIZE-2:FRA_SIZE];
         assign fr = (gi == 0) ? a0_reg[FRA_SIZE-1:0]        : b0_reg[FRA_SIZE-1:0];

         always_comb begin
            cls = CLS_NORM;
            if (ex == '0)
               cls = (fr == '0) ? CLS_ZERO : CLS_SUB;
            else if (ex == '1)
               cls = (fr == '0) ? CLS_INF : CLS_NAN;
         end

         assign cls_ftz = (cls == CLS_SUB) ? CLS_ZERO : cls;
         assign snan    = (cls == CLS_NAN) & ~fr[FRA_SIZE-1];
      end
   endgenerate

   logic            sign1_reg, snan1_reg;
   fp_class_e       cls1_a_reg, cls1_b_reg;
   logic [XW-1:0]   exp1_reg;
   logic [PW-1:0]   prod1_reg;

   always_ff @(posedge clk_44) begin
      if (advance) begin
         sign1_reg  <= a0_reg[REG_SIZE-1] ^ b0_reg[REG_SIZE-1];
         cls1_a_reg <= g_unpack[0].cls_ftz;
         cls1_b_reg <= g_unpack[1].cls_ftz;
         snan1_reg  <= g_unpack[0].snan | g_unpack[1].snan;
         // Modular arithmetic in XW bits yields the signed exponent sum.
         exp1_reg   <= XW'(g_unpack[0].ex) + XW'(g_unpack[1].ex) - XW'(BIAS);
         prod1_reg  <= PW'({1'b1, g_unpack[0].fr}) * PW'({1'b1, g_unpack[1].fr});
      end
   end

   // S2: normalise and round.
   logic [FRA_SIZE-1:0] frac_nr;
   logic [XW-1:0]       exp_nr;
   logic                inexact_nr;

   fp_norm_round #(.EXP_SIZE(EXP_SIZE), .FRA_SIZE(FRA_SIZE)) u_norm_round (
      .prod    (prod1_reg),
      .exp_in  (exp1_reg),
      .frac    (frac_nr),
      .exp_out (exp_nr),
      .inexact (inexact_nr)
   );

   logic                sign2_reg, snan2_reg, inexact2_reg;
   fp_class_e           cls2_a_reg, cls2_b_reg;
   logic [XW-1:0]       exp2_reg;
   logic [FRA_SIZE-1:0] frac2_reg;

   always_ff @(posedge clk_44) begin
      if (advance) begin
         sign2_reg    <= sign1_reg;
         snan2_reg    <= snan1_reg;
         cls2_a_reg   <= cls1_a_reg;
         cls2_b_reg   <= cls1_b_reg;
         exp2_reg     <= exp_nr;
         frac2_reg    <= frac_nr;
         inexact2_reg <= inexact_nr;
      end
   end

   // S3: special values first, then exponent range, then normal pack.
   logic [REG_SIZE-1:0] res_s3;
   logic [3:0]          flags_s3;
   logic                any_nan, inf_zero, any_inf, any_zero;

   always_comb begin
      any_nan  = (cls2_a_reg == CLS_NAN) | (cls2_b_reg == CLS_NAN);
      inf_zero = ((cls2_a_reg == CLS_INF) & (cls2_b_reg == CLS_ZERO)) |
                 ((cls2_a_reg == CLS_ZERO) & (cls2_b_reg == CLS_INF));
      any_inf  = (cls2_a_reg == CLS_INF) | (cls2_b_reg == CLS_INF);
      any_zero = (cls2_a_reg == CLS_ZERO) | (cls2_b_reg == CLS_ZERO);
      res_s3   = {sign2_reg, exp2_reg[EXP_SIZE-1:0], frac2_reg};
      flags_s3 = '0;
      flags_s3[FLAG_INEXACT] = inexact2_reg;
      if (any_nan || inf_zero) begin
         res_s3   = QNAN_W[REG_SIZE-1:0];
         flags_s3 = '0;
         flags_s3[FLAG_INVALID] = snan2_reg | inf_zero;
      end else if (any_inf) begin
         res_s3   = {sign2_reg, {EXP_SIZE{1'b1}}, {FRA_SIZE{1'b0}}};
         flags_s3 = '0;
      end else if (any_zero) begin
         res_s3   = {sign2_reg, {(REG_SIZE-1){1'b0}}};
         flags_s3 = '0;
      end else if ($signed(exp2_reg) >= $signed(XW'((1 << EXP_SIZE) - 1))) begin
         res_s3   = {sign2_reg, {EXP_SIZE{1'b1}}, {FRA_SIZE{1'b0}}};
         flags_s3 = '0;
         flags_s3[FLAG_OVERFLOW] = 1'b1;
         flags_s3[FLAG_INEXACT]  = 1'b1;
      end else if ($signed(exp2_reg) <= $signed(XW'(0))) begin
         res_s3   = {sign2_reg, {(REG_SIZE-1){1'b0}}};
         flags_s3 = '0;
         flags_s3[FLAG_UNDERFLOW] = 1'b1;
         flags_s3[FLAG_INEXACT]   = 1'b1;
      end
   end

   logic [REG_SIZE-1:0] out_reg;
   logic [3:0]          flags_reg;

   always_ff @(posedge clk_44) begin
      if (reset_44) begin
         out_reg   <= '0;
         flags_reg <= '0;
      end else if (advance) begin
         out_reg   <= res_s3;
         flags_reg <= flags_s3;
      end
   end

   assign bus.mult_out_44 = out_reg;
   assign bus.flags_44    = flags_reg;
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe: half and single precision instances on one clock.
// Vector tables feed a scoreboard queue on accept; monitors pop and compare
// on each output transfer. Hand sequences cover latency, stall and reset.
module tb_fp_mult_pipe;
   logic clk_44 = 1'b0;
   logic reset_44;
   always #5 clk_44 = ~clk_44;

   fp_mult_pipe_if #(.EXP_SIZE(5), .FRA_SIZE(10)) h_bus ();
   fp_mult_pipe_if #(.EXP_SIZE(8), .FRA_SIZE(23)) s_bus ();

   fp_mult_pipe #(.EXP_SIZE(5), .FRA_SIZE(10)) u_half (
      .clk_44(clk_44), .reset_44(reset_44), .bus(h_bus));
   fp_mult_pipe #(.EXP_SIZE(8), .FRA_SIZE(23)) u_single (
      .clk_44(clk_44), .reset_44(reset_44), .bus(s_bus));

   typedef struct { logic [31:0] a, b, r; logic [3:0] f; } vec_t;
   typedef struct { logic [31:0] res; logic [3:0] fl; } exp_t;

   vec_t htbl[$];
   vec_t stbl[$];
   exp_t h_q[$];
   exp_t s_q[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int h_out_n = 0;

   always @(posedge clk_44) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end else
         $display("[TB] %s ok: %h", nm, got);
   endtask

   task automatic add(input bit single, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic [3:0] f);
      vec_t v;
      v.a = a; v.b = b; v.r = r; v.f = f;
      if (single) stbl.push_back(v); else htbl.push_back(v);
   endtask

   // Call at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send_h(input vec_t v);
      int n = 0;
      logic took = 1'b0;
      exp_t e;
      h_bus.in_valid_44 = 1'b1;
      h_bus.mult_a_44   = v.a[15:0];
      h_bus.mult_b_44   = v.b[15:0];
      while (!took && n < 100) begin
         @(negedge clk_44);
         took = h_bus.in_ready_44;
         @(posedge clk_44);
         #1;
         n++;
      end
      if (took) begin
         e.res = v.r; e.fl = v.f;
         h_q.push_back(e);
         acc_cyc = cyc;
         $display("[TB] half  in  %h * %h expect %h flags %b", v.a[15:0], v.b[15:0], v.r[15:0], v.f);
      end else begin
         tests++; fails++;
         $display("FAIL half_accept_timeout: got in_ready=0 want 1 within 100 cycles");
      end
   endtask

   task automatic send_s(input vec_t v, input bit push);
      int n = 0;
      logic took = 1'b0;
      exp_t e;
      s_bus.in_valid_44 = 1'b1;
      s_bus.mult_a_44   = v.a;
      s_bus.mult_b_44   = v.b;
      while (!took && n < 100) begin
         @(negedge clk_44);
         took = s_bus.in_ready_44;
         @(posedge clk_44);
         #1;
         n++;
      end
      if (took && push) begin
         e.res = v.r; e.fl = v.f;
         s_q.push_back(e);
         $display("[TB] single in  %h * %h expect %h flags %b", v.a, v.b, v.r, v.f);
      end else if (!took) begin
         tests++; fails++;
         $display("FAIL single_accept_timeout: got in_ready=0 want 1 within 100 cycles");
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((h_q.size() != 0 || s_q.size() != 0) && n < 100) begin
         @(posedge clk_44);
         n++;
      end
      #1;
      chk("drain_pending", 32'(h_q.size() + s_q.size()), 32'd0);
   endtask

   // Half monitor: scoreboard pop on transfer, hold check while stalled.
   logic        h_hold_v = 1'b0;
   logic [15:0] h_hold_d;
   logic [3:0]  h_hold_f;
   exp_t        he;
   always @(negedge clk_44) begin
      if (reset_44) h_hold_v = 1'b0;
      else begin
         if (h_hold_v) begin
            tests++;
            if (!h_bus.out_valid_44 || h_bus.mult_out_44 !== h_hold_d || h_bus.flags_44 !== h_hold_f) begin
               fails++;
               $display("FAIL half_hold: got v=%b %h/%b want v=1 %h/%b",
                        h_bus.out_valid_44, h_bus.mult_out_44, h_bus.flags_44, h_hold_d, h_hold_f);
            end
         end
         if (h_bus.out_valid_44 && h_bus.out_ready_44) begin
            tests++;
            h_out_n++;
            if (h_q.size() == 0) begin
               fails++;
               $display("FAIL half_extra: got %h/%b with nothing pending", h_bus.mult_out_44, h_bus.flags_44);
            end else begin
               he = h_q.pop_front();
               if (h_bus.mult_out_44 !== he.res[15:0] || h_bus.flags_44 !== he.fl) begin
                  fails++;
                  $display("FAIL half_result: got %h/%b want %h/%b",
                           h_bus.mult_out_44, h_bus.flags_44, he.res[15:0], he.fl);
               end else
                  $display("[TB] half  out %h flags %b", h_bus.mult_out_44, h_bus.flags_44);
            end
         end
         h_hold_v = h_bus.out_valid_44 & ~h_bus.out_ready_44;
         h_hold_d = h_bus.mult_out_44;
         h_hold_f = h_bus.flags_44;
      end
   end

   exp_t se;
   always @(negedge clk_44) begin
      if (!reset_44 && s_bus.out_valid_44 && s_bus.out_ready_44) begin
         tests++;
         if (s_q.size() == 0) begin
            fails++;
            $display("FAIL single_extra: got %h/%b with nothing pending", s_bus.mult_out_44, s_bus.flags_44);
         end else begin
            se = s_q.pop_front();
            if (s_bus.mult_out_44 !== se.res || s_bus.flags_44 !== se.fl) begin
               fails++;
               $display("FAIL single_result: got %h/%b want %h/%b",
                        s_bus.mult_out_44, s_bus.flags_44, se.res, se.fl);
            end else
               $display("[TB] single out %h flags %b", s_bus.mult_out_44, s_bus.flags_44);
         end
      end
   end

   initial begin
      int b;
      int lat;
      int stall_n;
      int out_base;
      int post_rst_valid;

      add(0, 32'h3C00, 32'h3E00, 32'h3E00, 4'b0000);
      add(0, 32'h4000, 32'h4200, 32'h4600, 4'b0000);
      add(0, 32'h3C01, 32'h3C01, 32'h3C02, 4'b0001);
      add(0, 32'h7BFF, 32'h7BFF, 32'h7C00, 4'b0101);
      add(0, 32'h0400, 32'h0400, 32'h0000, 4'b0011);
      add(0, 32'h7C00, 32'h0000, 32'h7E00, 4'b1000);
      add(0, 32'h7D00, 32'h3C00, 32'h7E00, 4'b1000);
      add(0, 32'h8000, 32'h3C00, 32'h8000, 4'b0000);
      add(0, 32'h7E00, 32'h3C00, 32'h7E00, 4'b0000);
      add(0, 32'h7E00, 32'h0000, 32'h7E00, 4'b0000);
      add(0, 32'h7C00, 32'hBC00, 32'hFC00, 4'b0000);
      add(0, 32'h0000, 32'hFC00, 32'h7E00, 4'b1000);
      add(0, 32'h7C00, 32'h7C00, 32'h7C00, 4'b0000);
      add(0, 32'h8000, 32'h8000, 32'h0000, 4'b0000);
      add(0, 32'h0001, 32'h3C00, 32'h0000, 4'b0000);
      add(0, 32'h3C01, 32'h3E00, 32'h3E02, 4'b0001);
      add(0, 32'h3DA8, 32'h3DA8, 32'h4000, 4'b0001);
      add(0, 32'h0400, 32'h3C00, 32'h0400, 4'b0000);
      add(0, 32'h0400, 32'h3800, 32'h0000, 4'b0011);
      add(0, 32'h7BFF, 32'h3C00, 32'h7BFF, 4'b0000);
      add(0, 32'h7800, 32'h4000, 32'h7C00, 4'b0101);

      add(1, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
      add(1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000);
      add(1, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
      add(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101);
      add(1, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
      add(1, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);

      reset_44 = 1'b1;
      h_bus.in_valid_44 = 1'b0; h_bus.mult_a_44 = '0; h_bus.mult_b_44 = '0; h_bus.out_ready_44 = 1'b1;
      s_bus.in_valid_44 = 1'b0; s_bus.mult_a_44 = '0; s_bus.mult_b_44 = '0; s_bus.out_ready_44 = 1'b1;
      repeat (3) @(posedge clk_44);
      #1;
      reset_44 = 1'b0;
      @(negedge clk_44);
      chk("reset_out_valid", 32'(h_bus.out_valid_44), 32'd0);
      chk("reset_mult_out",  32'(h_bus.mult_out_44),  32'd0);
      chk("reset_flags",     32'(h_bus.flags_44),     32'd0);
      chk("reset_in_ready",  32'(h_bus.in_ready_44),  32'd1);
      @(posedge clk_44);
      #1;

      // Back-to-back half vectors.
      foreach (htbl[i]) send_h(htbl[i]);
      h_bus.in_valid_44 = 1'b0;
      drain();

      // Latency from an idle pipe; operand changes after accept must not matter.
      send_h(htbl[0]);
      h_bus.in_valid_44 = 1'b0;
      h_bus.mult_a_44   = 16'h1234;
      h_bus.mult_b_44   = 16'h7C00;
      lat = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_44);
         if (h_bus.out_valid_44) begin
            lat = cyc - acc_cyc;
            break;
         end
      end
      @(posedge clk_44);
      #1;
      chk("latency", 32'(lat), 32'd3);
      drain();

      // Eight back-to-back ops with the consumer stalling cycles 4..8.
      b = cyc;
      stall_n = 0;
      out_base = h_out_n;
      fork
         begin
            for (int i = 0; i < 8; i++) send_h(htbl[i + 1]);
            h_bus.in_valid_44 = 1'b0;
         end
         begin
            for (int k = 1; k <= 14; k++) begin
               @(posedge clk_44);
               #1;
               h_bus.out_ready_44 = !((cyc - b) >= 4 && (cyc - b) <= 8);
            end
            h_bus.out_ready_44 = 1'b1;
         end
         begin
            for (int k = 0; k < 16; k++) begin
               @(negedge clk_44);
               if (h_bus.out_valid_44 && !h_bus.out_ready_44) begin
                  stall_n++;
                  tests++;
                  if (h_bus.in_ready_44 !== 1'b0) begin
                     fails++;
                     $display("FAIL stall_in_ready: got %b want 0", h_bus.in_ready_44);
                  end
               end
            end
         end
      join
      drain();
      chk("stall_seen", 32'(stall_n > 0), 32'd1);
      chk("stall_out_count", 32'(h_out_n - out_base), 32'd8);

      // Single precision vectors.
      foreach (stbl[i]) send_s(stbl[i], 1'b1);
      s_bus.in_valid_44 = 1'b0;
      drain();

      // Two ops in flight, then reset: nothing may come out afterwards.
      send_s(stbl[0], 1'b0);
      send_s(stbl[1], 1'b0);
      s_bus.in_valid_44 = 1'b0;
      reset_44 = 1'b1;
      @(posedge clk_44);
      #1;
      reset_44 = 1'b0;
      post_rst_valid = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_44);
         if (s_bus.out_valid_44) post_rst_valid++;
      end
      chk("reset_inflight_outputs", 32'(post_rst_valid), 32'd0);
      @(posedge clk_44);
      #1;

      // Recovery after reset.
      send_s(stbl[0], 1'b1);
      s_bus.in_valid_44 = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
